// File: rtl/fir_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_pkg
// Brief    : Shared constants, types and the saturate helper for the
//            FIR output sampler.
// Revision : 1.0 - initial release
// ============================================================================
package fir_out_pkg;

    localparam int ACC_W_DEF      = 32;
    localparam int OUT_W_DEF      = 8;
    localparam int SHIFT_DEF      = 11;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    // Working width of the saturate helper; any ACC_W+1 up to this fits.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic             ovf;
        logic [SAT_W-1:0] value;
    } sat_res_t;

    // Clamp an unsigned value to the largest out_w-bit number.
    function automatic sat_res_t saturate(input logic [SAT_W-1:0] value,
                                          input int               out_w);
        sat_res_t         r;
        logic [SAT_W-1:0] max_v;
        max_v   = (SAT_W'(1) << out_w) - SAT_W'(1);
        r.ovf   = (value > max_v);
        r.value = r.ovf ? max_v : value;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_fifo
// Brief    : Synchronous first-word-fall-through FIFO with occupancy count.
//            A push while full is ignored unless a pop happens in the same
//            cycle. Storage is cleared on reset so the head reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q,  w_count_d;
    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full  = (r_count_q == c_CNT_W'(DEPTH));
    assign o_empty = (r_count_q == '0);
    assign o_count = r_count_q;
    assign o_dout  = r_mem_q[r_rd_ptr_q];

    // Accepted push/pop and the resulting pointer and count updates.
    always_comb begin
        w_do_pop   = i_pop && !o_empty;
        w_do_push  = i_push && (!o_full || w_do_pop);
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            if (w_do_push) begin
                r_mem_q[r_wr_ptr_q] <= i_din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_out_sampler.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_sampler
// Brief    : Per-frame FIR accumulator sampler. Takes the difference of
//            successive accumulator snapshots, shifts it down, saturates it
//            to OUT_W bits and queues it in a FWFT FIFO with valid/ready out.
//            Define FIR_OUT_ROUND_EN for round-half-up instead of truncation.
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_sampler
    import fir_out_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int SHIFT      = SHIFT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ACC_W-1:0]              acc_in,
    input  logic                          acc_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          sat_flag,
    output logic [15:0]                   drop_count
);

`ifdef FIR_OUT_ROUND_EN
    localparam int              c_RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W:0]  c_ROUND  = (SHIFT > 0) ?
                                           ((ACC_W+1)'(1) << c_RND_SH) : '0;
`endif

    logic [ACC_W-1:0] r_prev_acc_q,   w_prev_acc_d;
    logic [ACC_W-1:0] r_delta_q,      w_delta_d;
    logic             r_s1_valid_q,   w_s1_valid_d;
    logic             r_sat_flag_q,   w_sat_flag_d;
    logic [15:0]      r_drop_count_q, w_drop_count_d;

    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_scaled;
    sat_res_t         w_sat;
    logic [OUT_W-1:0] w_sample;
    logic             w_unused_sat_hi;
    logic             w_pop;
    logic             w_drop;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    // Stage 1: frame delta against the previous snapshot (wraps mod 2^ACC_W).
    always_comb begin
        w_prev_acc_d = r_prev_acc_q;
        w_delta_d    = r_delta_q;
        w_s1_valid_d = acc_valid;
        if (acc_valid) begin
            w_delta_d    = acc_in - r_prev_acc_q;
            w_prev_acc_d = acc_in;
        end
    end

    // Stage 2: scale (optionally rounded, one extra bit keeps the carry) and clamp.
    always_comb begin
`ifdef FIR_OUT_ROUND_EN
        w_sum = {1'b0, r_delta_q} + c_ROUND;
`else
        w_sum = {1'b0, r_delta_q};
`endif
        w_scaled        = w_sum >> SHIFT;
        w_sat           = saturate(SAT_W'(w_scaled), OUT_W);
        w_sample        = w_sat.value[OUT_W-1:0];
        w_unused_sat_hi = |w_sat.value[SAT_W-1:OUT_W];
    end

    // Sticky saturation flag and saturating drop counter.
    always_comb begin
        w_pop          = out_valid && out_ready;
        w_drop         = r_s1_valid_q && w_fifo_full && !w_pop;
        w_sat_flag_d   = r_sat_flag_q | (r_s1_valid_q & w_sat.ovf);
        w_drop_count_d = r_drop_count_q;
        if (w_drop && (r_drop_count_q != DROP_MAX)) begin
            w_drop_count_d = r_drop_count_q + 16'd1;
        end
    end

    // Pipeline and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_acc_q   <= '0;
            r_delta_q      <= '0;
            r_s1_valid_q   <= 1'b0;
            r_sat_flag_q   <= 1'b0;
            r_drop_count_q <= '0;
        end else begin
            r_prev_acc_q   <= w_prev_acc_d;
            r_delta_q      <= w_delta_d;
            r_s1_valid_q   <= w_s1_valid_d;
            r_sat_flag_q   <= w_sat_flag_d;
            r_drop_count_q <= w_drop_count_d;
        end
    end

    fir_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s1_valid_q),
        .i_din   (w_sample),
        .i_pop   (w_pop),
        .o_dout  (out_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign out_valid  = !w_fifo_empty;
    assign sat_flag   = r_sat_flag_q;
    assign drop_count = r_drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_out_sampler
// Brief    : Scoreboard bench for fir_out_sampler with a queue-level
//            reference model. Honours FIR_OUT_ROUND_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_out_sampler;

    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int SHIFT = 11;
    localparam int DEPTH = 4;
`ifdef FIR_OUT_ROUND_EN
    localparam int ROUND_EXP = 2;
`else
    localparam int ROUND_EXP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [ACC_W-1:0] acc_in = '0;
    logic             acc_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic [2:0]       fifo_count;
    logic             sat_flag;
    logic [15:0]      drop_count;

    fir_out_sampler #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_in     (acc_in),
        .acc_valid  (acc_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .sat_flag   (sat_flag),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [31:0] m_prev   = '0;
    bit        m_s1v    = 1'b0;
    int        m_s1_val = 0;
    bit        m_s1_ovf = 1'b0;
    int        m_cnt    = 0;
    bit        m_sat    = 1'b0;
    int        m_drop   = 0;
    int        exp_q[$];

    function automatic void calc(input bit [31:0] delta, output int sample,
                                 output bit ovf);
        longint unsigned d64;
        longint unsigned s;
        d64 = delta;
`ifdef FIR_OUT_ROUND_EN
        s = (d64 + (64'd1 << (SHIFT - 1))) >> SHIFT;
`else
        s = d64 >> SHIFT;
`endif
        ovf    = (s > 255);
        sample = ovf ? 255 : int'(s);
    endfunction

    always @(posedge clk) begin
        bit pop;
        bit push;
        if (rst) begin
            m_prev = '0;
            m_s1v  = 1'b0;
            m_cnt  = 0;
            m_sat  = 1'b0;
            m_drop = 0;
            exp_q.delete();
        end else begin
            pop  = (m_cnt > 0) && out_ready;
            push = m_s1v;
            if (push && m_s1_ovf) m_sat = 1'b1;
            if (pop) m_cnt--;
            if (push) begin
                if (m_cnt < DEPTH) begin
                    m_cnt++;
                    exp_q.push_back(m_s1_val);
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            m_s1v = acc_valid;
            if (acc_valid) begin
                calc(acc_in - m_prev, m_s1_val, m_s1_ovf);
                m_prev = acc_in;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid",  out_valid,  (m_cnt != 0));
            chk("fifo_count", fifo_count, m_cnt);
            chk("sat_flag",   sat_flag,   m_sat);
            chk("drop_count", drop_count, m_drop);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL out_data: got %0d, expected no sample", out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit v, input bit [31:0] a, input bit rdy);
        acc_valid = v;
        acc_in    = a;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1);
    endtask

    initial begin
        bit [31:0] a;

        // Reset state
        do_reset();
        mon_en = 1'b1;
        chk("rst_out_valid",  out_valid, 0);
        chk("rst_out_data",   out_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_sat_flag",   sat_flag, 0);
        chk("rst_drop_count", drop_count, 0);

        // First sample and two-cycle latency
        cyc(1, 400000, 0);
        chk("lat_early_valid", out_valid, 0);
        cyc(0, 0, 0);
        chk("lat_valid", out_valid, 1);
        chk("first_sample", out_data, 195);
        chk("first_count", fifo_count, 1);
        cyc(0, 0, 1);
        chk("after_pop_valid", out_valid, 0);

        // Delta, not absolute value
        do_reset();
        cyc(1, 400000, 0);
        cyc(1, 800000, 0);
        cyc(0, 0, 0);
        chk("delta_head", out_data, 195);
        chk("delta_count", fifo_count, 2);
        cyc(0, 0, 1);
        chk("delta_second", out_data, 195);
        drain(3);

        // Accumulator wrap
        do_reset();
        cyc(1, 32'hFFFF_F000, 0);
        cyc(1, 32'h0000_0800, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        chk("wrap_sample", out_data, 3);
        drain(3);

        // Saturation, sticky flag
        do_reset();
        cyc(1, 32'h0010_0000, 0);
        cyc(0, 0, 0);
        chk("sat_sample", out_data, 255);
        chk("sat_set", sat_flag, 1);
        cyc(1, 32'h0010_1000, 1);
        drain(4);
        chk("sat_sticky", sat_flag, 1);

        // Overflow: 6 strobes into a stalled 4-deep FIFO
        do_reset();
        a = 0;
        for (int i = 0; i < 6; i++) begin
            a = a + 32'((i + 1) * 4096);
            cyc(1, a, 0);
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_drops", drop_count, 2);
        chk("ovf_head", out_data, 2);
        drain(6);

        // Full with simultaneous push and pop: no drop
        for (int i = 0; i < 4; i++) begin
            a = a + 32'd8192;
            cyc(1, a, 0);
        end
        a = a + 32'd20480;
        cyc(1, a, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("fullpp_count", fifo_count, 4);
        chk("fullpp_drops", drop_count, 2);
        drain(6);

        // Rounding behaviour
        do_reset();
        cyc(1, 3072, 0);
        cyc(0, 0, 0);
        chk("round_sample", out_data, ROUND_EXP);
        drain(2);

        // Reset in the middle of the pipeline
        cyc(1, 500000, 0);
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", fifo_count, 0);
        drain(3);
        chk("midrst_no_stale", out_valid, 0);

        // Randomized traffic
        do_reset();
        a = 0;
        for (int i = 0; i < 600; i++) begin
            bit v;
            bit rdy;
            v = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 15) == 0) a = $urandom();
            else a = a + 32'($urandom_range(0, 700000));
            if ((i / 100) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
            else rdy = ($urandom_range(0, 4) == 0);
            cyc(v, a, rdy);
        end
        drain(10);
        chk("scoreboard_empty", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
